// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: FSM state encoding and
// the operation codes understood by the external ALU.
package alu_issue_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_AND = 1'b1;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU: accepts one request,
// drives the ALU for one cycle, holds the captured result until consumed.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iOpA,
  input  logic [WIDTH-1:0] iOpB,
  input  logic             iOp,
  output logic [WIDTH-1:0] oAluA,
  output logic [WIDTH-1:0] oAluB,
  output logic             oAluSel,
  input  logic [WIDTH-1:0] iAluResult,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oOp,
  output logic [CNT_W-1:0] oCount
);

  logic [1:0] state;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state   <= S_IDLE;
      oAluA   <= '0;
      oAluB   <= '0;
      oAluSel <= 1'b0;
      oResult <= '0;
      oOp     <= 1'b0;
      oCount  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iValid) begin
            oAluA   <= iOpA;
            oAluB   <= iOpB;
            oAluSel <= iOp;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ALU drive registers are stable here, so its result is settled.
          oResult <= iAluResult;
          oOp     <= oAluSel;
          state   <= S_DONE;
        end
        S_DONE: begin
          if (iReady) begin
            oCount <= oCount + CNT_W'(1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    oReady = (state == S_IDLE);
    oValid = (state == S_DONE);
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural external ALU.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iValid;
  logic          oReady;
  logic [W-1:0]  iOpA, iOpB;
  logic          iOp;
  logic [W-1:0]  oAluA, oAluB;
  logic          oAluSel;
  logic [W-1:0]  iAluResult;
  logic          oValid;
  logic          iReady;
  logic [W-1:0]  oResult;
  logic          oOp;
  logic [CW-1:0] oCount;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  typedef struct {
    int a;
    int b;
    int op;
    int res;
  } vec_t;

  vec_t vecs[8];

  always #5 iClk = ~iClk;

  // External ALU
  always_comb begin
    if (oAluSel == OP_AND) iAluResult = oAluA & oAluB;
    else                   iAluResult = oAluA + oAluB;
  end

  alu_issue_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady),
    .iOpA(iOpA), .iOpB(iOpB), .iOp(iOp),
    .oAluA(oAluA), .oAluB(oAluB), .oAluSel(oAluSel), .iAluResult(iAluResult),
    .oValid(oValid), .iReady(iReady), .oResult(oResult), .oOp(oOp),
    .oCount(oCount)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int op);
    if (op != 0) return a & b;
    return (a + b) % (1 << W);
  endfunction

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_valid"}, 32'(oValid), 0);
    chk({pfx, "_ready"}, 32'(oReady), 1);
    chk({pfx, "_alua"}, 32'(oAluA), 0);
    chk({pfx, "_alub"}, 32'(oAluB), 0);
    chk({pfx, "_alusel"}, 32'(oAluSel), 0);
    chk({pfx, "_result"}, 32'(oResult), 0);
    chk({pfx, "_op"}, 32'(oOp), 0);
    chk({pfx, "_count"}, 32'(oCount), 0);
  endtask

  // Issues one request at a negedge while idle; returns at a negedge idle again.
  task automatic run_txn(input int a, input int b, input int op,
                         input int stall, input bit early_ready);
    int exp;
    exp = ref_alu(a, b, op);
    chk("idle_ready", 32'(oReady), 1);
    chk("idle_valid", 32'(oValid), 0);
    iValid = 1'b1; iOpA = W'(a); iOpB = W'(b); iOp = op[0];
    iReady = early_ready;
    @(posedge iClk); @(negedge iClk);
    chk("exec_ready", 32'(oReady), 0);
    chk("exec_valid", 32'(oValid), 0);
    chk("drive_a", 32'(oAluA), 32'(a));
    chk("drive_b", 32'(oAluB), 32'(b));
    chk("drive_sel", 32'(oAluSel), 32'(op));
    iValid = 1'($urandom); iOpA = W'($urandom); iOpB = W'($urandom); iOp = 1'($urandom);
    @(posedge iClk); @(negedge iClk);
    chk("done_valid", 32'(oValid), 1);
    chk("done_ready", 32'(oReady), 0);
    chk("result", 32'(oResult), 32'(exp));
    chk("op_tag", 32'(oOp), 32'(op));
    chk("count_before_hs", 32'(oCount), 32'(model_count));
    if (!early_ready) begin
      for (int i = 0; i < stall; i++) begin
        iReady = 1'b0; iValid = 1'b1; iOpA = W'($urandom); iOp = 1'($urandom);
        @(posedge iClk); @(negedge iClk);
        chk("stall_valid", 32'(oValid), 1);
        chk("stall_ready", 32'(oReady), 0);
        chk("stall_result", 32'(oResult), 32'(exp));
        chk("stall_op", 32'(oOp), 32'(op));
        chk("stall_count", 32'(oCount), 32'(model_count));
        chk("stall_drive_a", 32'(oAluA), 32'(a));
      end
    end
    iReady = 1'b1; iValid = 1'($urandom);
    @(posedge iClk); @(negedge iClk);
    iReady = 1'b0; iValid = 1'b0;
    model_count = (model_count + 1) % (1 << CW);
    chk("hs_valid", 32'(oValid), 0);
    chk("hs_ready", 32'(oReady), 1);
    chk("hs_count", 32'(oCount), 32'(model_count));
    chk("hold_drive_a", 32'(oAluA), 32'(a));
    chk("hold_drive_sel", 32'(oAluSel), 32'(op));
  endtask

  initial begin
    vecs[0] = '{a: 5,  b: 7,  op: 0, res: 12};
    vecs[1] = '{a: 5,  b: 10, op: 1, res: 0};
    vecs[2] = '{a: 12, b: 10, op: 1, res: 8};
    vecs[3] = '{a: 9,  b: 9,  op: 0, res: 2};
    vecs[4] = '{a: 15, b: 1,  op: 0, res: 0};
    vecs[5] = '{a: 15, b: 15, op: 1, res: 15};
    vecs[6] = '{a: 0,  b: 0,  op: 0, res: 0};
    vecs[7] = '{a: 6,  b: 3,  op: 1, res: 2};

    iRst_n = 1'b0; iValid = 1'b0; iOpA = '0; iOpB = '0; iOp = 1'b0; iReady = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    chk_reset_state("rst");
    iRst_n = 1'b1;

    // Directed table, alternating immediate / stalled / early-ready consumers
    for (int i = 0; i < 8; i++) begin
      chk("vec_model", 32'(ref_alu(vecs[i].a, vecs[i].b, vecs[i].op)), 32'(vecs[i].res));
      run_txn(vecs[i].a, vecs[i].b, vecs[i].op, (i == 3) ? 5 : (i % 3), (i % 4) == 2);
    end

    for (int i = 0; i < 40; i++)
      run_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom));

    // Reset while DONE with a simultaneous consumer handshake
    iValid = 1'b1; iOpA = 4'd3; iOpB = 4'd4; iOp = 1'b0;
    @(posedge iClk); @(negedge iClk);
    iValid = 1'b0;
    @(posedge iClk); @(negedge iClk);
    chk("pre_rst_done_valid", 32'(oValid), 1);
    iRst_n = 1'b0; iReady = 1'b1;
    @(posedge iClk); @(negedge iClk);
    chk_reset_state("rst_done");
    iRst_n = 1'b1; iReady = 1'b0;
    model_count = 0;

    run_txn(2, 3, 0, 1, 1'b0);

    // Reset while EXEC with iValid/iReady asserted
    iValid = 1'b1; iOpA = 4'd11; iOpB = 4'd13; iOp = 1'b1;
    @(posedge iClk); @(negedge iClk);
    chk("pre_rst_exec_ready", 32'(oReady), 0);
    iRst_n = 1'b0; iReady = 1'b1;
    @(posedge iClk); @(negedge iClk);
    chk_reset_state("rst_exec");
    iRst_n = 1'b1; iReady = 1'b0; iValid = 1'b0;
    model_count = 0;
    @(posedge iClk); @(negedge iClk);
    chk("post_rst_idle_valid", 32'(oValid), 0);

    // 256 back-to-back transactions wrap the counter to zero
    for (int i = 0; i < 256; i++)
      run_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)), 0, 1'b1);
    chk("wrap_count", 32'(oCount), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
